// File: rtl/scaler_frame_ctrl.sv
// Frame sequencer for the scaler pair: latches per-frame dimensions, issues
// scaler restart/step strobes and walks the output raster on AXI-Stream.
module scaler_frame_ctrl #(
    parameter int C_S_WIDTH = 12,
    parameter int C_M_WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [C_S_WIDTH-1:0] cfg_s_width,
    input  logic [C_S_WIDTH-1:0] cfg_s_height,
    input  logic [C_M_WIDTH-1:0] cfg_m_width,
    input  logic [C_M_WIDTH-1:0] cfg_m_height,
    input  logic                 cfg_wr,
    input  logic                 start,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_err,
    output logic [C_S_WIDTH-1:0] h_s_nbr,
    output logic [C_M_WIDTH-1:0] h_m_nbr,
    output logic [C_S_WIDTH-1:0] v_s_nbr,
    output logic [C_M_WIDTH-1:0] v_m_nbr,
    output logic                 h_restart,
    output logic                 v_restart,
    output logic                 h_step,
    output logic                 v_step,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_user,
    output logic                 m_last,
    output logic [C_M_WIDTH-1:0] m_x,
    output logic [C_M_WIDTH-1:0] m_y
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_LSTART = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [C_S_WIDTH-1:0] S_ZERO = {C_S_WIDTH{1'b0}};
    localparam logic [C_M_WIDTH-1:0] M_ZERO = {C_M_WIDTH{1'b0}};
    localparam logic [C_M_WIDTH-1:0] M_ONE  = {{(C_M_WIDTH-1){1'b0}}, 1'b1};

    state_t                 state_r, state_next_s;
    logic [C_S_WIDTH-1:0]   sh_s_width_r, sh_s_height_r;
    logic [C_M_WIDTH-1:0]   sh_m_width_r, sh_m_height_r;
    logic [C_S_WIDTH-1:0]   act_s_width_r, act_s_height_r;
    logic [C_M_WIDTH-1:0]   act_m_width_r, act_m_height_r;
    logic [C_M_WIDTH-1:0]   x_r, y_r;
    logic                   busy_r, done_r, cfg_err_r, m_valid_r;
    logic                   h_restart_r, v_restart_r;
    logic                   shadow_zero_s, active_zero_s;
    logic                   accept_s, x_end_s, y_end_s;

    assign shadow_zero_s = (sh_s_width_r == S_ZERO) | (sh_s_height_r == S_ZERO) |
                           (sh_m_width_r == M_ZERO) | (sh_m_height_r == M_ZERO);
    assign active_zero_s = (act_s_width_r == S_ZERO) | (act_s_height_r == S_ZERO) |
                           (act_m_width_r == M_ZERO) | (act_m_height_r == M_ZERO);
    assign accept_s = m_valid_r & m_ready;
    assign x_end_s  = (x_r == act_m_width_r - M_ONE);
    assign y_end_s  = (y_r == act_m_height_r - M_ONE);

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode; abort wins over start and over beat completion
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start && !abort) state_next_s = ST_LOAD;
                else                 state_next_s = ST_IDLE;
            end
            ST_LOAD: begin
                if (abort)              state_next_s = ST_IDLE;
                else if (active_zero_s) state_next_s = ST_DONE;
                else                    state_next_s = ST_LSTART;
            end
            ST_LSTART: begin
                if (abort) state_next_s = ST_IDLE;
                else       state_next_s = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (abort)                        state_next_s = ST_IDLE;
                else if (accept_s && x_end_s)     state_next_s = y_end_s ? ST_DONE : ST_LSTART;
                else                              state_next_s = ST_ACTIVE;
            end
            ST_DONE:  state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // Shadow capture and active copy; the copy lands as LOAD is entered so the
    // scalers see stable dimensions throughout their restart pulses
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sh_s_width_r   <= S_ZERO;
            sh_s_height_r  <= S_ZERO;
            sh_m_width_r   <= M_ZERO;
            sh_m_height_r  <= M_ZERO;
            act_s_width_r  <= S_ZERO;
            act_s_height_r <= S_ZERO;
            act_m_width_r  <= M_ZERO;
            act_m_height_r <= M_ZERO;
            cfg_err_r      <= 1'b0;
        end else begin
            if (cfg_wr) begin
                sh_s_width_r  <= cfg_s_width;
                sh_s_height_r <= cfg_s_height;
                sh_m_width_r  <= cfg_m_width;
                sh_m_height_r <= cfg_m_height;
            end
            if (state_r == ST_IDLE && state_next_s == ST_LOAD) begin
                act_s_width_r  <= sh_s_width_r;
                act_s_height_r <= sh_s_height_r;
                act_m_width_r  <= sh_m_width_r;
                act_m_height_r <= sh_m_height_r;
                cfg_err_r      <= shadow_zero_s;
            end
        end
    end

    // Raster counters; they saturate at the last beat instead of wrapping
    always_ff @(posedge clk) begin
        if (!resetn) begin
            x_r <= M_ZERO;
            y_r <= M_ZERO;
        end else begin
            if (state_r == ST_LOAD)   y_r <= M_ZERO;
            if (state_r == ST_LSTART) x_r <= M_ZERO;
            if (accept_s) begin
                if (!x_end_s)     x_r <= x_r + M_ONE;
                else if (!y_end_s) y_r <= y_r + M_ONE;
            end
        end
    end

    // Control outputs registered from the next state
    always_ff @(posedge clk) begin
        if (!resetn) begin
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            m_valid_r   <= 1'b0;
            h_restart_r <= 1'b0;
            v_restart_r <= 1'b0;
        end else begin
            busy_r      <= (state_next_s != ST_IDLE);
            done_r      <= (state_next_s == ST_DONE);
            m_valid_r   <= (state_next_s == ST_ACTIVE);
            h_restart_r <= (state_next_s == ST_LSTART);
            v_restart_r <= (state_next_s == ST_LOAD) & ~shadow_zero_s;
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign cfg_err   = cfg_err_r;
    assign h_s_nbr   = act_s_width_r;
    assign h_m_nbr   = act_m_width_r;
    assign v_s_nbr   = act_s_height_r;
    assign v_m_nbr   = act_m_height_r;
    assign h_restart = h_restart_r;
    assign v_restart = v_restart_r;
    assign m_valid   = m_valid_r;
    assign h_step    = accept_s;
    assign v_step    = accept_s & x_end_s & ~y_end_s;
    assign m_user    = m_valid_r & (x_r == M_ZERO) & (y_r == M_ZERO);
    assign m_last    = m_valid_r & x_end_s;
    assign m_x       = x_r;
    assign m_y       = y_r;

endmodule

// File: tb/tb_scaler_frame_ctrl.sv
// Directed bench for scaler_frame_ctrl: frame timing, raster order,
// stall stability, config errors, abort and mid-frame reconfiguration.
module tb_scaler_frame_ctrl;

    localparam int SW = 12;
    localparam int MW = 12;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [SW-1:0] cfg_s_width = '0, cfg_s_height = '0;
    logic [MW-1:0] cfg_m_width = '0, cfg_m_height = '0;
    logic          cfg_wr = 1'b0, start = 1'b0, abort = 1'b0, m_ready = 1'b0;
    logic          busy, done, cfg_err, h_restart, v_restart, h_step, v_step;
    logic          m_valid, m_user, m_last;
    logic [SW-1:0] h_s_nbr, v_s_nbr;
    logic [MW-1:0] h_m_nbr, v_m_nbr, m_x, m_y;

    int n_checks = 0;
    int n_errors = 0;

    scaler_frame_ctrl #(.C_S_WIDTH(SW), .C_M_WIDTH(MW)) dut (
        .clk(clk), .resetn(resetn),
        .cfg_s_width(cfg_s_width), .cfg_s_height(cfg_s_height),
        .cfg_m_width(cfg_m_width), .cfg_m_height(cfg_m_height),
        .cfg_wr(cfg_wr), .start(start), .abort(abort),
        .busy(busy), .done(done), .cfg_err(cfg_err),
        .h_s_nbr(h_s_nbr), .h_m_nbr(h_m_nbr), .v_s_nbr(v_s_nbr), .v_m_nbr(v_m_nbr),
        .h_restart(h_restart), .v_restart(v_restart), .h_step(h_step), .v_step(v_step),
        .m_valid(m_valid), .m_ready(m_ready), .m_user(m_user), .m_last(m_last),
        .m_x(m_x), .m_y(m_y)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_cfg(input int sw, input int sh, input int mw, input int mh);
        @(negedge clk);
        cfg_s_width  = SW'(sw);
        cfg_s_height = SW'(sh);
        cfg_m_width  = MW'(mw);
        cfg_m_height = MW'(mh);
        cfg_wr = 1'b1;
        @(negedge clk);
        cfg_wr = 1'b0;
    endtask

    // Starts a frame and follows it cycle by cycle (cycle 1 = LOAD).
    // ax/ay >= 0 aborts on that beat; wr_beat >= 0 pulses cfg_wr at that beat count.
    task automatic run_frame(input int w, input int h, input bit rnd,
                             input int ax, input int ay, input int wr_beat);
        int cyc = 0, beats = 0, hs = 0, vs = 0, users = 0, lasts = 0, dones = 0;
        int hr = 0, excl = 0, first_valid = -1, vr_cyc = -1, hr_cyc = -1, done_cyc = -1;
        int ex = 0, ey = 0, exp_beats;
        bit fin = 1'b0, stalled = 1'b0, wr_done = 1'b0, aborted;
        logic [26:0] prev_s = '0;
        aborted   = (ax >= 0);
        exp_beats = aborted ? (ay * w + ax + 1) : (w * h);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!fin && cyc < 3000) begin
            m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            cfg_wr  = (wr_beat >= 0) && (beats == wr_beat) && !wr_done;
            if (cfg_wr) wr_done = 1'b1;
            #1;
            if (stalled)
                check_val("stall_hold", 32'({m_valid, m_user, m_last, m_x, m_y}), 32'(prev_s));
            if (int'(h_restart) + int'(v_restart) + int'(done) > 1 || (h_step && h_restart))
                excl++;
            if (v_restart && vr_cyc < 0) vr_cyc = cyc;
            if (h_restart && hr_cyc < 0) hr_cyc = cyc;
            if (m_valid && first_valid < 0) first_valid = cyc;
            hr    += int'(h_restart);
            hs    += int'(h_step);
            vs    += int'(v_step);
            dones += int'(done);
            if (m_valid && m_ready) begin
                check_val("beat_x", 32'(m_x), 32'(ex));
                check_val("beat_y", 32'(m_y), 32'(ey));
                check_val("beat_user", 32'(m_user), 32'(ex == 0 && ey == 0));
                check_val("beat_last", 32'(m_last), 32'(ex == w - 1));
                check_val("beat_vstep", 32'(v_step), 32'(ex == w - 1 && ey != h - 1));
                beats++;
                users += int'(m_user);
                lasts += int'(m_last);
                if (aborted && ex == ax && ey == ay) abort = 1'b1;
                if (ex == w - 1) begin
                    ex = 0;
                    ey++;
                end else begin
                    ex++;
                end
            end
            if (!m_valid && (m_user || m_last)) excl++;
            if (done) begin
                done_cyc = cyc;
                fin = 1'b1;
            end
            stalled = m_valid && !m_ready;
            prev_s  = {m_valid, m_user, m_last, m_x, m_y};
            @(negedge clk);
            cfg_wr = 1'b0;
            cyc++;
            if (abort) begin
                abort = 1'b0;
                #1;
                check_val("abort_valid", 32'(m_valid), 32'd0);
                check_val("abort_busy", 32'(busy), 32'd0);
                check_val("abort_done", 32'(done), 32'd0);
                fin = 1'b1;
            end
        end
        m_ready = 1'b0;
        check_val("timeout", 32'(cyc >= 3000), 32'd0);
        check_val("vrst_cycle", 32'(vr_cyc), 32'd1);
        check_val("hrst_cycle", 32'(hr_cyc), 32'd2);
        check_val("first_valid", 32'(first_valid), 32'd3);
        check_val("beats", 32'(beats), 32'(exp_beats));
        check_val("hstep_cnt", 32'(hs), 32'(exp_beats));
        check_val("vstep_cnt", 32'(vs), 32'(aborted ? ay : h - 1));
        check_val("hrst_cnt", 32'(hr), 32'(aborted ? ay + 1 : h));
        check_val("user_cnt", 32'(users), 32'd1);
        check_val("last_cnt", 32'(lasts), 32'(aborted ? (ay + ((ax == w - 1) ? 1 : 0)) : h));
        check_val("done_cnt", 32'(dones), 32'(aborted ? 0 : 1));
        check_val("strobe_excl", 32'(excl), 32'd0);
        check_val("h_m_nbr", 32'(h_m_nbr), 32'(w));
        check_val("v_m_nbr", 32'(v_m_nbr), 32'(h));
        if (!rnd && !aborted)
            check_val("done_cycle", 32'(done_cyc), 32'(3 + w * h + h - 1));
        if (!aborted) begin
            #1;
            check_val("idle_after", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_err", 32'(cfg_err), 32'd0);
        check_val("rst_valid", 32'(m_valid), 32'd0);
        check_val("rst_xy", 32'({m_x, m_y}), 32'd0);
        check_val("rst_nbr", 32'({h_m_nbr, v_s_nbr}), 32'd0);
        resetn = 1'b1;

        // nominal frame, then the same frame under random back-pressure
        do_cfg(5, 4, 30, 2);
        run_frame(30, 2, 1'b0, -1, -1, -1);
        check_val("h_s_nbr", 32'(h_s_nbr), 32'd5);
        check_val("v_s_nbr", 32'(v_s_nbr), 32'd4);
        run_frame(30, 2, 1'b1, -1, -1, -1);

        // zero output width: error path straight to DONE
        do_cfg(5, 4, 0, 2);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check_val("zero_vrst", 32'(v_restart), 32'd0);
        check_val("zero_busy", 32'(busy), 32'd1);
        @(negedge clk);
        #1;
        check_val("zero_done", 32'(done), 32'd1);
        check_val("zero_err", 32'(cfg_err), 32'd1);
        check_val("zero_valid", 32'(m_valid), 32'd0);
        check_val("zero_hrst", 32'(h_restart), 32'd0);
        @(negedge clk);
        #1;
        check_val("zero_idle", 32'({busy, done, m_valid}), 32'd0);

        // reconfiguration during a frame only affects the following frame
        do_cfg(5, 4, 30, 2);
        cfg_s_width  = SW'(8);
        cfg_s_height = SW'(8);
        cfg_m_width  = MW'(16);
        cfg_m_height = MW'(16);
        run_frame(30, 2, 1'b0, -1, -1, 10);
        check_val("err_clear", 32'(cfg_err), 32'd0);
        run_frame(16, 16, 1'b0, -1, -1, -1);
        check_val("new_s_nbr", 32'(h_s_nbr), 32'd8);

        // abort on beat (12,1), then a clean frame
        do_cfg(5, 4, 30, 2);
        run_frame(30, 2, 1'b0, 12, 1, -1);
        run_frame(30, 2, 1'b0, -1, -1, -1);

        // single-column output
        do_cfg(1, 1, 1, 3);
        run_frame(1, 3, 1'b0, -1, -1, -1);

        // reset in the middle of a frame clears shadow and active state
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        #1;
        check_val("mrst_ctrl", 32'({busy, done, m_valid, cfg_err}), 32'd0);
        check_val("mrst_nbr", 32'({h_m_nbr, v_m_nbr}), 32'd0);
        check_val("mrst_y", 32'(m_y), 32'd0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #1;
        check_val("mrst_shadow_err", 32'(cfg_err), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/scaler_frame_ctrl.md
Name: scaler_frame_ctrl

Overview:
Frame sequencer for the axis scaler datapath. Holds per-frame source and destination dimensions and loads them into the horizontal and vertical common scaler instances. It restarts each scaler at frame and line boundaries and walks the output raster. Each accepted output beat carries x/y coordinates plus start-of-frame and end-of-line markers, so the scaler pair stays in lockstep with the output AXI-Stream.

Parameters:
C_S_WIDTH, 12, bit width of source dimensions (s_width, s_height).
C_M_WIDTH, 12, bit width of destination dimensions and of the m_x/m_y counters.

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
cfg_s_width  in  C_S_WIDTH  source pixels per line
cfg_s_height  in  C_S_WIDTH  source lines per frame
cfg_m_width  in  C_M_WIDTH  output pixels per line
cfg_m_height  in  C_M_WIDTH  output lines per frame
cfg_wr  in  1  one-cycle strobe; copies cfg_* into the shadow registers
start  in  1  frame start request
abort  in  1  abandon the current frame
busy  out  1  frame in progress
done  out  1  one-cycle pulse at frame end
cfg_err  out  1  sticky flag: last start saw a zero dimension
h_s_nbr  out  C_S_WIDTH  active source width, to horizontal scaler s_nbr
h_m_nbr  out  C_M_WIDTH  active output width, to horizontal scaler m_nbr
v_s_nbr  out  C_S_WIDTH  active source height, to vertical scaler s_nbr
v_m_nbr  out  C_M_WIDTH  active output height, to vertical scaler m_nbr
h_restart  out  1  one-cycle pulse; horizontal scaler reinitialises
v_restart  out  1  one-cycle pulse; vertical scaler reinitialises
h_step  out  1  horizontal scaler advance strobe (= m_valid & m_ready)
v_step  out  1  vertical scaler advance strobe (one per completed line except the last)
m_valid  out  1  output beat valid
m_ready  in  1  downstream accepts beat
m_user  out  1  start of frame (x==0, y==0)
m_last  out  1  end of line (x==active width-1)
m_x  out  C_M_WIDTH  output column
m_y  out  C_M_WIDTH  output row

Behaviour:
- Reset (resetn low at a clk edge): state IDLE.
  - Shadow and active dimension registers = 0.
  - All outputs 0, including busy, done, cfg_err, m_valid, strobes, m_x and m_y.
- Shadow registers:
  - Written on every cfg_wr, in any state.
  - Copied into the active registers (h_*/v_* outputs) only in LOAD.
  - Active values never change mid-frame.
- States:
  - IDLE: busy=0. start=1 -> LOAD.
  - LOAD (1 cycle): busy=1; copy shadow to active; clear cfg_err.
    - If any shadow dimension is 0: set cfg_err, go to DONE, assert no restart pulse.
    - Otherwise assert v_restart, clear m_y, go to LSTART.
  - LSTART (1 cycle): assert h_restart, clear m_x, go to ACTIVE.
  - ACTIVE: m_valid=1. On m_valid & m_ready, assert h_step and m_x++.
    - Beat with m_x==h_m_nbr-1 (m_last=1):
      - If m_y==v_m_nbr-1: go to DONE.
      - Else: assert v_step, m_y++, go to LSTART.
  - DONE (1 cycle): done=1, busy=0 next cycle, go to IDLE.
- Handshake:
  - m_valid never drops while in ACTIVE without acceptance.
  - m_x, m_y, m_user and m_last stay stable while m_valid & !m_ready.
- Latency:
  - start to first m_valid: 3 cycles (IDLE, LOAD, LSTART).
  - Line turnaround: one bubble cycle (LSTART) between a line's last beat and the next line's first beat.
- Markers: m_user=1 only on beat (0,0); m_last=1 on each line's final beat; both are 0 whenever m_valid=0.
- start while busy: ignored.
- abort:
  - From LOAD, LSTART or ACTIVE: go to IDLE at the next edge with m_valid=0, done not pulsed, busy=0.
  - Any beat already accepted in that same cycle still counts, with its h_step.
  - abort has priority over start.
- Simultaneous cfg_wr and LOAD: LOAD copies the pre-write shadow; the new values apply to the next frame.
- Width-1 lines (h_m_nbr==1): each beat has m_last=1; on frame (0,0) m_user and m_last are both 1.
- Counters: m_x and m_y never exceed active dimension-1; no wrap-around inside a frame.
- Strobe exclusivity: h_restart, v_restart and done are mutually exclusive in time. h_step never coincides with h_restart.
- Reset mid-frame: immediate return to reset values at the next edge. Shadow registers are also cleared.

Test Plan:
- cfg 5x4 -> 30x2, cfg_wr, start, m_ready=1 -> v_restart in cycle 1 and h_restart in cycle 2; 30 beats with m_last on x=29; one bubble; 30 more beats; done pulse; 60 h_step, exactly 1 v_step, m_user only on the first beat.
- Same config, m_ready random 50% -> beat fields stable while stalled; still 60 accepted beats with correct (x,y) sequence; h_step count = 60.
- cfg_m_width=0, start -> cfg_err=1, no m_valid, no restart pulses, done pulsed 2 cycles after start.
- Mid-frame cfg_wr with 8x8 -> 16x16 -> current frame finishes at 30x2; next start gives h_m_nbr=16 and 256 beats.
- abort at beat (12,1) with m_ready=1 -> that beat is accepted, m_valid=0 next cycle, busy=0, no done; a following start runs a complete frame from (0,0).
- cfg 1x1 -> 1x3 -> three beats, each with m_last=1, m_user on the first; 2 v_step; done once.
